// File: rtl/nunchuck_pkg.sv
// Shared constants and state type for the Nunchuck report frame decoder.
package nunchuck_pkg;

    localparam int unsigned FRAME_LEN = 6;
    localparam int unsigned CNT_W     = 3;

    localparam int unsigned IDX_JX  = 0;
    localparam int unsigned IDX_JY  = 1;
    localparam int unsigned IDX_BTN = 5;

    localparam logic [7:0] DECRYPT_KEY = 8'h17;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/nunchuck_frame_decoder_iir.sv
// First-order IIR smoother: acc += (sample - acc) >>> FILT_SHIFT; the first load after reset primes acc directly.
module nunchuck_iir #(
    parameter int unsigned FILT_SHIFT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] sample,
    output logic [7:0] acc
);

    logic              primed;
    logic signed [8:0] diff;
    logic signed [8:0] step;
    logic        [7:0] acc_next;

    // The step magnitude never exceeds |diff|, so the 8-bit sum cannot wrap.
    always_comb begin
        diff     = $signed({1'b0, sample}) - $signed({1'b0, acc});
        step     = diff >>> FILT_SHIFT;
        acc_next = acc + step[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= 8'd0;
            primed <= 1'b0;
        end else if (load) begin
            acc    <= primed ? acc_next : sample;
            primed <= 1'b1;
        end
    end

endmodule

// File: rtl/nunchuck_frame_decoder.sv
// Assembles 6-byte Nunchuck reports, smooths the selected joystick axis and decodes the buttons.
// Optional feature macro: NUNCHUCK_DECRYPT_EN (legacy-init byte de-obfuscation on store).
module nunchuck_frame_decoder
    import nunchuck_pkg::*;
#(
    parameter int unsigned FILT_SHIFT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_start,
    output logic       in_ready,
    input  logic       sel_axis,
    output logic [3:0] data,
    output logic       data_valid,
    output logic       btn_z,
    output logic       btn_c,
    output logic       frame_err
);

    state_t             state, state_next;
    logic [CNT_W-1:0]   count, count_next;
    logic [7:0]         byte_jx, byte_jy, byte_btn;
    logic [7:0]         stored;
    logic [CNT_W-1:0]   idx;
    logic               xfer;
    logic               store;
    logic               load;
    logic               err_next;
    logic [7:0]         acc;

`ifdef NUNCHUCK_DECRYPT_EN
    assign stored = (in_data ^ DECRYPT_KEY) + DECRYPT_KEY;
`else
    assign stored = in_data;
`endif

    // Ready is a pure function of state, forced low while reset is held.
    assign in_ready = ~rst & (state != COMMIT);
    assign xfer     = in_valid & in_ready;
    assign store    = xfer & (in_start | (state == COLLECT));
    assign idx      = in_start ? CNT_W'(0) : count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        err_next   = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (xfer && in_start) begin
                    count_next = CNT_W'(1);
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (xfer) begin
                    if (in_start) begin
                        err_next   = 1'b1;
                        count_next = CNT_W'(1);
                    end else begin
                        count_next = count + CNT_W'(1);
                        if (count == CNT_W'(FRAME_LEN - 1))
                            state_next = COMMIT;
                    end
                end
            end
            COMMIT: begin
                load       = 1'b1;
                count_next = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Only the axis bytes and the button byte are kept; accelerometer bytes are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_jx  <= 8'd0;
            byte_jy  <= 8'd0;
            byte_btn <= 8'd0;
        end else if (store) begin
            if (idx == CNT_W'(IDX_JX))  byte_jx  <= stored;
            if (idx == CNT_W'(IDX_JY))  byte_jy  <= stored;
            if (idx == CNT_W'(IDX_BTN)) byte_btn <= stored;
        end
    end

    nunchuck_iir #(
        .FILT_SHIFT (FILT_SHIFT)
    ) u_iir (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .sample (sel_axis ? byte_jy : byte_jx),
        .acc    (acc)
    );

    assign data = acc[7:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            btn_z      <= 1'b0;
            btn_c      <= 1'b0;
        end else begin
            data_valid <= load;
            frame_err  <= err_next;
            if (load) begin
                btn_z <= ~byte_btn[0];
                btn_c <= ~byte_btn[1];
            end
        end
    end

endmodule

// File: tb/tb_nunchuck_frame_decoder.sv
// Directed self-checking bench for nunchuck_frame_decoder (FILT_SHIFT=2).
module tb_nunchuck_frame_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_start;
    logic       in_ready;
    logic       sel_axis;
    logic [3:0] data;
    logic       data_valid;
    logic       btn_z;
    logic       btn_c;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int dv_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    nunchuck_frame_decoder #(.FILT_SHIFT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_start   (in_start),
        .in_ready   (in_ready),
        .sel_axis   (sel_axis),
        .data       (data),
        .data_valid (data_valid),
        .btn_z      (btn_z),
        .btn_c      (btn_c),
        .frame_err  (frame_err)
    );

    always @(negedge clk) begin
        if (data_valid) dv_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds in_valid until the byte is transferred; leaves in_valid asserted.
    task automatic send_byte(input logic [7:0] b, input logic s);
        logic r;
        int   n;
        in_data  = b;
        in_start = s;
        in_valid = 1'b1;
        n = 0;
        do begin
            r = in_ready;
            step();
            n++;
        end while (!r && n < 20);
        chk("xfer_timeout", 32'(r), 32'd1);
    endtask

    task automatic send_frame(input logic [47:0] f, input logic hold);
        for (int i = 0; i < 6; i++)
            send_byte(f[47 - 8*i -: 8], i == 0);
        if (!hold) begin
            in_valid = 1'b0;
            in_start = 1'b0;
        end
    endtask

    // Called in the COMMIT cycle; checks the C+2 strobe and the hold afterwards.
    task automatic check_commit(input string tag, input logic [3:0] d, input logic z, input logic c);
        chk({tag, "_ready_commit"}, 32'(in_ready), 32'd0);
        chk({tag, "_dv_early"}, 32'(data_valid), 32'd0);
        step();
        chk({tag, "_dv"}, 32'(data_valid), 32'd1);
        chk({tag, "_data"}, 32'(data), 32'(d));
        chk({tag, "_btn_z"}, 32'(btn_z), 32'(z));
        chk({tag, "_btn_c"}, 32'(btn_c), 32'(c));
        step();
        chk({tag, "_dv_single"}, 32'(data_valid), 32'd0);
        chk({tag, "_data_hold"}, 32'(data), 32'(d));
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_start = 1'b0;
        in_data  = 8'd0;
        step();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_dv", 32'(data_valid), 32'd0);
        chk("rst_btn", 32'({btn_z, btn_c}), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int dv0, err0;
        sel_axis = 1'b0;
        do_reset();

`ifdef NUNCHUCK_DECRYPT_EN
        send_frame(48'h17_17_17_17_17_00, 1'b0);
        check_commit("decrypt", 4'h1, 1'b1, 1'b0);
`else
        // First frame primes the filter: acc = F0.
        send_frame(48'hF0_80_00_00_00_FC, 1'b0);
        check_commit("f0", 4'hF, 1'b1, 1'b1);

        // acc = F0 + (-240 >>> 2) = B4.
        send_frame(48'h00_80_00_00_00_FE, 1'b0);
        check_commit("f1", 4'hB, 1'b1, 1'b0);

        // Non-start bytes in IDLE are dropped.
        dv0 = dv_cnt;
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b0);
        in_valid = 1'b0;
        step();
        step();
        chk("drop_dv_cnt", 32'(dv_cnt), 32'(dv0));
        chk("drop_data", 32'(data), 32'hB);
        chk("drop_btn", 32'({btn_z, btn_c}), 32'b10);

        // Restart mid-frame: new frame X=40, acc = B4 - 29 = 97.
        dv0  = dv_cnt;
        err0 = err_cnt;
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h40, 1'b1);
        chk("restart_err", 32'(frame_err), 32'd1);
        send_byte(8'h80, 1'b0);
        chk("restart_err_single", 32'(frame_err), 32'd0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        in_valid = 1'b0;
        in_start = 1'b0;
        check_commit("restart", 4'h9, 1'b0, 1'b0);
        chk("restart_err_cnt", 32'(err_cnt - err0), 32'd1);
        chk("restart_dv_cnt", 32'(dv_cnt - dv0), 32'd1);

        // Valid held across COMMIT, Y axis: 97 -> 89 -> 8E.
        sel_axis = 1'b1;
        dv0  = dv_cnt;
        err0 = err_cnt;
        send_frame(48'h50_60_00_00_00_FF, 1'b1);
        chk("hold_ready_commit", 32'(in_ready), 32'd0);
        send_frame(48'h70_A0_00_00_00_FC, 1'b0);
        check_commit("hold", 4'h8, 1'b1, 1'b1);
        chk("hold_dv_cnt", 32'(dv_cnt - dv0), 32'd2);
        chk("hold_err_cnt", 32'(err_cnt - err0), 32'd0);

        // Reset after byte 4, then the next frame primes directly with Y=7F.
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        err0 = err_cnt;
        do_reset();
        send_frame(48'h12_7F_00_00_00_FF, 1'b0);
        check_commit("prime", 4'h7, 1'b0, 1'b0);
        chk("prime_err_cnt", 32'(err_cnt - err0), 32'd0);
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
